dm_copy_engine: RTL and testbench
=================================

# dm_copy_engine

Memory-side initiator for the word-addressed data memory (DM). On a `start` pulse it copies a block of 32-bit words from a source word index to a destination word index. It does this by driving DM's `memRead`/`memWrite`/`address`/`writeData` port set and sampling `memOut`, and it accumulates a running checksum of the copied data. It sits beside the pipeline as a bus master, muxed onto DM's ports while `busy` is high.

## Interface
- `ADDR_W`, default 5: DM word-index width (32 words).
- `DATA_W`, default 32: word width.
- `TOP_WORD`, default 29: highest writable DM word. Words 30–31 are hardwired constants.
- `clk` input, 1 bit: single clock. All state updates on posedge.
- `reset` input, 1 bit: **synchronous, active-low**.
- `start` input, 1 bit: request. Sampled only in IDLE.
- `srcAddr` input, ADDR_W bits: first source word index.
- `dstAddr` input, ADDR_W bits: first destination word index.
- `len` input, ADDR_W+1 bits: word count, 0..32.
- `memOut` input, DATA_W bits: DM read data, combinational from `address`.
- `memRead` output, 1 bit: DM read enable.
- `memWrite` output, 1 bit: DM write enable. DM captures on the negedge inside the cycle.
- `address` output, ADDR_W bits: DM word index.
- `writeData` output, DATA_W bits: DM write data.
- `busy` output, 1 bit: high in READ/WRITE.
- `done` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: range-violation flag for the last request. Held until next accepted start.
- `checksum` output, DATA_W bits: sum of words written in the last transfer, mod 2^DATA_W.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, on `start`=1: latch `srcAddr`, `dstAddr`, `len`. Clear the index `i`, `checksum` and `err`.
  - Range check in ADDR_W+1 bits: violation if `srcAddr+len > 32` or (`len≠0` and `dstAddr+len-1 > TOP_WORD`).
  - Violation → `err`=1, go to DONE with no memory access.
  - `len`=0 → go to DONE.
  - Otherwise → READ.
- READ:
  - Drive `memRead`=1, `address`=src+i, `memWrite`=0.
  - At posedge capture `memOut` into the data register, then go to WRITE.
- WRITE:
  - Drive `memWrite`=1, `memRead`=0, `address`=dst+i, `writeData`=data register.
  - At posedge: `checksum += data register`, `i++`.
  - Go to DONE if `i+1==len`, else READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- In all states other than READ/WRITE, `memRead`, `memWrite`, `address` and `writeData` are 0.
- Overlap: the copy is strictly forward, word by word. When `dst>src` and the ranges overlap, the source pattern replicates; this is defined, required behaviour.
- `start` during READ/WRITE/DONE is ignored, and the latched parameters are unaffected.
- Address arithmetic never wraps, because the range check rejects any wrap case.

## Timing
- Reset (`reset`=0 at a posedge):
  - State goes to IDLE.
  - `busy`, `done`, `err`, `memRead`, `memWrite`, `address`, `writeData` and `checksum` all become 0.
- Reset mid-transfer takes effect at the next posedge. A DM write already in a WRITE cycle completes at that cycle's negedge. No further accesses follow.
- Start accepted at posedge t0:
  - READ occupies cycle t0+1.
  - WRITE occupies cycle t0+2.
  - Word k is read in cycle t0+1+2k and written in cycle t0+2+2k.
  - `done` is high in cycle t0+2·len+1.
  - `len`=0 or an error gives `done` in cycle t0+1.
- `busy` is high for exactly 2·len cycles.
- `checksum` is final when `done` is high and holds until the next accepted start.
- Outputs are decoded from registered state plus registered datapath, with no combinational path from `start`.
- `memOut` is used only as the capture source at the READ posedge.

## Structure
- Shared package `dm_pkg`:
  - state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3);
  - `DM_WORDS`=32;
  - `DM_TOP_WORD`=29.
- No sub-module. The bench instantiates the existing DM as the responder and observes its contents directly.

## Test plan
- Reset, then DM words 0–3 preloaded with 0x11,0x22,0x33,0x44; start src=0, dst=10, len=4:
  - words 10–13 = 0x11..0x44;
  - `done` at t0+9;
  - `checksum`=0xAA;
  - `err`=0.
- Start src=30, dst=0, len=2: words 0,1 = 0x00000001 each; `checksum`=2.
- Start len=0: `done` at t0+1, `busy` never high, no `memWrite`.
- Start dst=28, len=3: `err`=1, `done` at t0+1, no DM write, DM unchanged.
- Overlap: words 0,1 = 5,7; src=0, dst=1, len=2 → words 1,2 = 5,5.
- Reset asserted in the first WRITE cycle of a len=4 copy:
  - only the first word is copied;
  - all outputs 0 next cycle;
  - `start` re-accepted afterwards.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory copy engine.
// State encoding and data-memory geometry constants.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dm_state_e;

    localparam int DM_WORDS    = 32;
    localparam int DM_TOP_WORD = 29;

endpackage

// File: rtl/dm_copy_engine.sv
// Bus-master block copier for the word-addressed data memory.
// Ports: clk, reset (sync, active-low); start/srcAddr/dstAddr/len request;
//        memOut read data in; memRead/memWrite/address/writeData to DM;
//        busy, done pulse, err flag, checksum of copied words.
import dm_pkg::*;

module dm_copy_engine #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int TOP_WORD = DM_TOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] memOut,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] SRC_LIM = (ADDR_W+1)'(DM_WORDS);
    localparam logic [ADDR_W:0] TOP_LIM = (ADDR_W+1)'(TOP_WORD);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              err_q, err_d;

    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_last;
    logic              range_bad;
    logic [ADDR_W:0]   idx_nxt;

    // Range check is done one bit wider than the address so that
    // src+len and dst+len-1 cannot wrap for any legal len.
    always_comb begin
        src_end   = {1'b0, srcAddr} + len;
        dst_last  = {1'b0, dstAddr} + len - ONE;
        range_bad = (src_end > SRC_LIM) ||
                    ((len != '0) && (dst_last > TOP_LIM));
    end

    assign idx_nxt = idx_q + ONE;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d      = srcAddr;
                    dst_d      = dstAddr;
                    len_d      = len;
                    idx_d      = '0;
                    checksum_d = '0;
                    err_d      = range_bad;
                    if (range_bad || (len == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                data_d  = memOut;
                state_d = WRITE;
            end
            WRITE: begin
                checksum_d = checksum_q + data_q;
                idx_d      = idx_nxt;
                state_d    = (idx_nxt == len_q) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    // Bus outputs decode only registered state, so start has no
    // combinational path to DM.
    always_comb begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        unique case (state_q)
            READ: begin
                memRead = 1'b1;
                address = src_q + idx_q[ADDR_W-1:0];
            end
            WRITE: begin
                memWrite  = 1'b1;
                address   = dst_q + idx_q[ADDR_W-1:0];
                writeData = data_q;
            end
            default: begin
                memRead = 1'b0;
            end
        endcase
    end

    assign busy     = (state_q == READ) || (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Testbench for dm_copy_engine with a behavioural DM responder.
// Copies are predicted by a word-level reference model of memory.
module tb_dm_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  srcAddr;
    logic [4:0]  dstAddr;
    logic [5:0]  len;
    logic [31:0] memOut;
    logic        memRead;
    logic        memWrite;
    logic [4:0]  address;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] dm      [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_wd  [32];

    always #5 clk = ~clk;

    dm_copy_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .srcAddr   (srcAddr),
        .dstAddr   (dstAddr),
        .len       (len),
        .memOut    (memOut),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    // DM responder: words 30-31 read as constant 1, writes on negedge.
    assign memOut = (address >= 5'd30) ? 32'd1 : dm[address];

    always @(negedge clk) begin
        if (memWrite && address <= 5'd29) dm[address] <= writeData;
    end

    function automatic logic [31:0] ref_read(input int a);
        return (a >= 30) ? 32'd1 : ref_mem[a];
    endfunction

    // Word-level copy model; updates ref_mem in copy order.
    task automatic model_copy(input int s, input int d, input int n,
                              output bit e, output logic [31:0] cs);
        cs = 32'd0;
        e  = (s + n > 32) || (n != 0 && d + n - 1 > 29);
        if (!e) begin
            for (int k = 0; k < n; k++) begin
                exp_wd[k] = ref_read(s + k);
                ref_mem[d + k] = exp_wd[k];
                cs = cs + exp_wd[k];
            end
        end
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        dm[a]      = v;
        ref_mem[a] = v;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 30; a++) begin
            vectors++;
            if (dm[a] !== ref_mem[a]) begin
                miscompares++;
                $display("FAIL %s mem[%0d]: got %h expected %h",
                         tag, a, dm[a], ref_mem[a]);
            end
        end
    endtask

    task automatic run_xfer(input string tag, input int s, input int d,
                            input int n, input bit poke);
        bit          e;
        logic [31:0] cs;
        bit          got;
        int          busy_n;
        int          done_c;
        bit          exp_rd, exp_wr, exp_done;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          k;
        model_copy(s, d, n, e, cs);
        done_c = (e || n == 0) ? 1 : 2 * n + 1;
        @(negedge clk);
        start   = 1'b1;
        srcAddr = 5'(s);
        dstAddr = 5'(d);
        len     = 6'(n);
        @(posedge clk);
        #1;
        start   = 1'b0;
        srcAddr = 5'($urandom);
        dstAddr = 5'($urandom);
        len     = 6'($urandom);
        got     = 1'b0;
        busy_n  = 0;
        for (int c = 1; c <= 2 * n + 4 && !got; c++) begin
            @(negedge clk);
            if (poke && !e && n >= 2 && c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (busy) busy_n++;
            k        = (c - 1) / 2;
            exp_rd   = !e && c <= 2 * n && (c % 2 == 1);
            exp_wr   = !e && c <= 2 * n && (c % 2 == 0);
            exp_addr = exp_rd ? 5'(s + k) : exp_wr ? 5'(d + k) : 5'd0;
            exp_data = exp_wr ? exp_wd[k] : 32'd0;
            exp_done = (c == done_c);
            vectors++;
            if ({memRead, memWrite, address, writeData, done} !==
                {exp_rd, exp_wr, exp_addr, exp_data, exp_done}) begin
                miscompares++;
                $display("FAIL %s bus c=%0d: got rd=%b wr=%b a=%0d wd=%h dn=%b expected rd=%b wr=%b a=%0d wd=%h dn=%b",
                         tag, c, memRead, memWrite, address, writeData, done,
                         exp_rd, exp_wr, exp_addr, exp_data, exp_done);
            end
            if (done) begin
                got = 1'b1;
                vectors++;
                if ({err, checksum} !== {e, cs}) begin
                    miscompares++;
                    $display("FAIL %s result: got err=%b cs=%h expected err=%b cs=%h",
                             tag, err, checksum, e, cs);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: got no done expected done at c=%0d",
                     tag, done_c);
        end
        vectors++;
        if (busy_n != (e ? 0 : 2 * n)) begin
            miscompares++;
            $display("FAIL %s busy cycles: got %0d expected %0d",
                     tag, busy_n, e ? 0 : 2 * n);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, err, checksum} !== {1'b0, 1'b0, e, cs}) begin
            miscompares++;
            $display("FAIL %s hold: got dn=%b bz=%b err=%b cs=%h expected dn=0 bz=0 err=%b cs=%h",
                     tag, done, busy, err, checksum, e, cs);
        end
        check_mem(tag);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        len     = '0;
        for (int a = 0; a < 32; a++) preload(a, $urandom);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, err, memRead, memWrite, address, writeData, checksum} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got bz=%b dn=%b err=%b rd=%b wr=%b a=%0d wd=%h cs=%h expected all 0",
                     busy, done, err, memRead, memWrite, address, writeData, checksum);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        preload(0, 32'h11);
        preload(1, 32'h22);
        preload(2, 32'h33);
        preload(3, 32'h44);
        run_xfer("basic", 0, 10, 4, 1'b0);
        vectors++;
        if ({dm[10], dm[11], dm[12], dm[13], checksum} !==
            {32'h11, 32'h22, 32'h33, 32'h44, 32'hAA}) begin
            miscompares++;
            $display("FAIL basic words: got %h %h %h %h cs=%h expected 11 22 33 44 cs=aa",
                     dm[10], dm[11], dm[12], dm[13], checksum);
        end
    endtask

    task automatic test_const_words();
        run_xfer("const", 30, 0, 2, 1'b0);
        vectors++;
        if ({dm[0], dm[1], checksum} !== {32'd1, 32'd1, 32'd2}) begin
            miscompares++;
            $display("FAIL const words: got %h %h cs=%h expected 1 1 cs=2",
                     dm[0], dm[1], checksum);
        end
    endtask

    task automatic test_len0();
        run_xfer("len0", 5, 7, 0, 1'b0);
    endtask

    task automatic test_err();
        run_xfer("err_dst", 0, 28, 3, 1'b0);
        run_xfer("err_src", 31, 0, 2, 1'b0);
        run_xfer("edge_ok", 29, 29, 1, 1'b0);
    endtask

    task automatic test_overlap();
        preload(0, 32'd5);
        preload(1, 32'd7);
        run_xfer("overlap", 0, 1, 2, 1'b0);
        vectors++;
        if ({dm[1], dm[2]} !== {32'd5, 32'd5}) begin
            miscompares++;
            $display("FAIL overlap words: got %h %h expected 5 5", dm[1], dm[2]);
        end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 4; a++) preload(a, $urandom);
        for (int a = 10; a < 14; a++) preload(a, $urandom);
        @(negedge clk);
        start   = 1'b1;
        srcAddr = 5'd0;
        dstAddr = 5'd10;
        len     = 6'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({memWrite, address} !== {1'b1, 5'd10}) begin
            miscompares++;
            $display("FAIL rst_mid write: got wr=%b a=%0d expected wr=1 a=10",
                     memWrite, address);
        end
        reset       = 1'b0;
        ref_mem[10] = ref_mem[0];
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, err, memRead, memWrite, address, writeData, checksum} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid outputs: got bz=%b dn=%b err=%b rd=%b wr=%b a=%0d wd=%h cs=%h expected all 0",
                     busy, done, err, memRead, memWrite, address, writeData, checksum);
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({memRead, memWrite} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_mid idle: got rd=%b wr=%b expected 0 0",
                         memRead, memWrite);
            end
        end
        check_mem("rst_mid");
        run_xfer("rst_restart", 0, 20, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int s, d, n;
        for (int t = 0; t < 25; t++) begin
            s = $urandom_range(0, 31);
            d = $urandom_range(0, 31);
            n = $urandom_range(0, 10);
            if (t == 24) begin
                s = 0;
                d = 0;
                n = 30;
            end
            run_xfer("random", s, d, n, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_const_words();
        test_len0();
        test_err();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
